// File: rtl/mau_pkg.sv
// mau_pkg: shared types and constants for the memory access unit.
//   size_e  : request size encodings (byte, half, word, reserved)
//   state_e : controller states; the read-modify-write states exist only
//             when MAU_SUBWORD_RMW_EN is defined
//   CNT_W   : width of the read-latency down-counter
//   is_misaligned() : alignment rule applied when a request is accepted
package mau_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

`ifdef MAU_SUBWORD_RMW_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_RESP = 3'd5
  } state_e;
`endif

  // The reserved size is reported as misaligned so that it shares the
  // same no-bus-activity error path.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational byte-lane handling, little-endian lanes.
//   word_in   : 32-bit bus word (read data or old word for a merge)
//   size      : access size
//   offset    : byte offset within the word (addr[1:0])
//   sign_ext  : sign-extend sub-word loads when 1, zero-extend when 0
//   new_data  : right-justified store data (only 16 bits can ever land)
//   load_data : selected lane, extended to 32 bits (word passes through)
//   merged    : word_in with the target lane replaced by new_data
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [31:0] word_in,
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [15:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = word_in[{offset, 3'b000} +: 8];
    lane_h    = offset[1] ? word_in[31:16] : word_in[15:0];
    load_data = word_in;
    merged    = word_in;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
        merged[{offset, 3'b000} +: 8] = new_data[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
        if (offset[1]) merged[31:16] = new_data;
        else           merged[15:0]  = new_data;
      end
      default: begin
        load_data = word_in;
        merged    = word_in;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side bus initiator. Takes one load/store at a time
// over a valid/ready handshake, drives the memory controller strobes and
// returns a single-cycle response.
//
// Configuration macro: MAU_SUBWORD_RMW_EN
//   defined   : byte/half stores run a read-modify-write sequence
//   undefined : byte/half stores are rejected with resp_error, no bus access
//
// Parameter RD_LATENCY (1..15): cycles a read strobe is held before the
// read word is sampled.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready, req_write, req_size, req_signed, req_addr, req_wdata
//   resp_valid, resp_rdata, resp_error
//   cpu_read_mem, cpu_write_mem, mem_addr, mem_wdata, mem_rdata, mem_error
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a request
// ST_RD     | load: read strobe held, latency counter running
// ST_WR     | word store: one write strobe cycle
// ST_RMW_RD | sub-word store: read old word (counter running)
// ST_RMW_WR | sub-word store: write merged word
// ST_RESP   | one-cycle response pulse
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        cpu_read_mem,
  output logic        cpu_write_mem,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_error
);

  state_e state, state_nxt;

  size_e            r_size;
  logic             r_signed;
  logic [31:0]      r_addr;
  logic [15:0]      r_wdata;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic [31:0]      wdata_q;
  logic             err_q;

  logic accept;
  logic req_bad;
  logic cnt_dec;
  logic capture;
  logic merge_ld;
  logic set_err;

  logic [31:0] load_data;
  logic [31:0] merged;

  mau_lane_align u_lane_align (
    .word_in   (mem_rdata),
    .size      (r_size),
    .offset    (r_addr[1:0]),
    .sign_ext  (r_signed),
    .new_data  (r_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // Ready is forced low while reset is held, independent of the state.
  assign req_ready = rst && (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef MAU_SUBWORD_RMW_EN
  assign req_bad = is_misaligned(req_size, req_addr[1:0]);
`else
  assign req_bad = is_misaligned(req_size, req_addr[1:0]) ||
                   (req_write && (req_size != SZ_WORD));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_dec   = 1'b0;
    capture   = 1'b0;
    merge_ld  = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_bad) begin
            state_nxt = ST_RESP;
            set_err   = 1'b1;
          end else if (!req_write) begin
            state_nxt = ST_RD;
          end else if (req_size == SZ_WORD) begin
            state_nxt = ST_WR;
          end else begin
`ifdef MAU_SUBWORD_RMW_EN
            state_nxt = ST_RMW_RD;
`else
            state_nxt = ST_RESP;
            set_err   = 1'b1;
`endif
          end
        end
      end
      ST_RD: begin
        // A bus error ends the read at once; no data is captured.
        if (mem_error) begin
          state_nxt = ST_RESP;
          set_err   = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = ST_RESP;
          capture   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR: begin
        state_nxt = ST_RESP;
        set_err   = mem_error;
      end
`ifdef MAU_SUBWORD_RMW_EN
      ST_RMW_RD: begin
        if (mem_error) begin
          state_nxt = ST_RESP;
          set_err   = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = ST_RMW_WR;
          merge_ld  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RMW_WR: begin
        state_nxt = ST_RESP;
        set_err   = mem_error;
      end
`endif
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        r_size   <= size_e'(req_size);
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata[15:0];
        cnt      <= CNT_W'(RD_LATENCY - 1);
        rdata_q  <= '0;
        wdata_q  <= req_wdata;
        err_q    <= 1'b0;
      end else if (cnt_dec) begin
        cnt <= cnt - 1'b1;
      end
      if (capture)  rdata_q <= load_data;
      if (merge_ld) wdata_q <= merged;
      if (set_err)  err_q   <= 1'b1;
    end
  end

  // Strobes decode straight from the state register so that an async
  // reset drops them without waiting for a clock edge.
`ifdef MAU_SUBWORD_RMW_EN
  assign cpu_read_mem  = (state == ST_RD) || (state == ST_RMW_RD);
  assign cpu_write_mem = (state == ST_WR) || (state == ST_RMW_WR);
`else
  assign cpu_read_mem  = (state == ST_RD);
  assign cpu_write_mem = (state == ST_WR);
`endif

  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_error = resp_valid && err_q;
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = wdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

CPU-side bus initiator that drives the memory controller port (read/write strobes, word address, write data) and collects its read data and error flag. It accepts one load/store request at a time from the CPU pipeline over a valid/ready handshake. It performs byte-lane alignment, sign/zero extension and sub-word read-modify-write. It returns a single-cycle response with data and error status.

## Interface
Parameters:
- RD_LATENCY, 1: cycles a read strobe is held before read data is sampled (legal range 1–15).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  unit idle, request accepted when req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  input  1  sign-extend sub-word loads
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  load result, extended; 0 on stores and errors
- resp_error  output  1  access failed
- cpu_read_mem  output  1  bus read strobe
- cpu_write_mem  output  1  bus write strobe
- mem_addr  output  32  word address {req_addr[31:2],2'b00}
- mem_wdata  output  32  bus write word
- mem_rdata  input  32  bus read word
- mem_error  input  1  bus error (decode/flash)

## Operation
- States: IDLE, RD (hold strobe, count), WR (one cycle), RMW_RD, RMW_WR, RESP.
- Lanes are little-endian. Byte n occupies bits [8n+7:8n], with n = req_addr[1:0]. The half at req_addr[1] occupies bits [16*req_addr[1]+15 : 16*req_addr[1]].
- Alignment check at accept: a half with addr[0]=1, a word with addr[1:0]≠0, or size 11 goes to RESP with resp_error=1. No bus activity occurs.
- Load: IDLE→RD. Strobe is held RD_LATENCY cycles. Then the selected lane is extracted and zero- or sign-extended per req_signed.
- Word store: IDLE→WR. mem_wdata = req_wdata.
- Sub-word store: IDLE→RMW_RD→RMW_WR. The read word is captured. Only the target lane is replaced with req_wdata[7:0] or [15:0], and the merged word is written.
- mem_error is sampled every cycle either strobe is high. If it is 1, the strobe drops next cycle, the FSM goes to RESP with resp_error=1 and resp_rdata=0, and any RMW write phase is skipped.
- Request fields are registered at accept. Input changes after acceptance are ignored.

## Timing
- Acceptance occurs in cycle T. req_ready=1 only in IDLE.
- Load: strobe in T+1..T+RD_LATENCY, mem_rdata sampled at the end of T+RD_LATENCY, resp_valid in T+RD_LATENCY+1.
- Word store: cpu_write_mem in T+1, resp_valid in T+2.
- RMW: read in T+1..T+RD_LATENCY, write in T+RD_LATENCY+1, resp_valid in T+RD_LATENCY+2.
- Alignment error: resp_valid in T+1.
- resp_valid lasts exactly one cycle with no backpressure. The FSM is in IDLE the following cycle, so the next request can be accepted at T_resp+1.
- cpu_read_mem and cpu_write_mem are never high together. mem_addr and mem_wdata are stable while a strobe is high.
- Reset values: req_ready=0 during reset, then 1. All other outputs are 0.
- Reset asserted mid-access drops the strobes immediately (asynchronously), discards the request and produces no response.

## Configuration
- MAU_SUBWORD_RMW_EN defined: sub-word stores use the RMW sequence above.
- MAU_SUBWORD_RMW_EN undefined:
  - RMW_RD and RMW_WR are not built.
  - A byte or half store returns resp_error=1 at T+1 with no bus activity.
  - Word stores and all loads are unchanged.

## Structure
- mau_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - the state enum
  - the RD_LATENCY counter width constant (4 bits)
- One combinational sub-module, mau_lane_align, handles lane extraction with sign/zero extension and store merge (old word, new data, size, offset → merged word). The FSM and registers stay in mem_access_unit.

## Test plan
- Word load, RD_LATENCY=2, addr 0x100, mem_rdata=0xDEADBEEF → cpu_read_mem high 2 cycles, resp_valid at T+3, rdata 0xDEADBEEF, error 0.
- Signed byte load at addr 0x103 with word 0x80000000 → rdata 0xFFFFFF80. The same access unsigned → 0x00000080.
- Half store 0xABCD at 0x102 over old word 0x11223344, RMW enabled → one read, then a write of 0xABCD3344, resp at T+RD_LATENCY+2.
- Misaligned word load at 0x101 → resp_error=1 at T+1, no strobe ever high. The same check with a size-11 request gives the same result.
- mem_error=1 during the read phase of an RMW store → no write strobe, resp_error=1, rdata 0.
- rst low during an RD hold → strobe low asynchronously, no resp_valid. After release, a new word store to 0x200 completes normally.
